// File: rtl/reg_writeback.sv
// Register file write-side controller: arbitrates ALU results against in-order
// load completions, tracks outstanding load tags and exports a busy vector.
module reg_writeback #(
  parameter int DEPTH = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_ce,
  input  logic        i_alu_valid,
  input  logic [3:0]  i_alu_rd,
  input  logic [15:0] i_alu_data,
  output logic        o_alu_ready,
  input  logic        i_ld_issue,
  input  logic [3:0]  i_ld_rd,
  output logic        o_ld_ready,
  input  logic        i_ld_valid,
  input  logic [15:0] i_ld_data,
  output logic        o_we,
  output logic [3:0]  o_w_addr,
  output logic [15:0] o_w_data,
  output logic [15:0] o_busy,
  output logic        o_err
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [3:0]    tags [DEPTH];
  logic [PW-1:0] rptr, wptr;
  logic [CW-1:0] count;
  logic          issue, resp, pop, alu_acc;
  logic          wr_en;
  logic [3:0]    wr_addr, head;
  logic [15:0]   wr_data;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign o_ld_ready  = i_ce && (count < CW'(DEPTH));
  assign o_alu_ready = i_ce && !i_ld_valid;
  assign issue       = i_ld_issue && o_ld_ready;
  assign resp        = i_ce && i_ld_valid;
  assign pop         = resp && (count != '0);
  assign alu_acc     = i_alu_valid && o_alu_ready;
  assign head        = tags[rptr];

  // Load responses win; writes to R0 complete the handshake but never assert we.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = i_alu_rd;
    wr_data = i_alu_data;
    if (pop) begin
      wr_en   = (head != 4'd0);
      wr_addr = head;
      wr_data = i_ld_data;
    end else if (alu_acc) begin
      wr_en = (i_alu_rd != 4'd0);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rptr     <= '0;
      wptr     <= '0;
      count    <= '0;
      o_we     <= 1'b0;
      o_w_addr <= '0;
      o_w_data <= '0;
      o_err    <= 1'b0;
    end else if (i_ce) begin
      o_we <= wr_en;
      if (wr_en) begin
        o_w_addr <= wr_addr;
        o_w_data <= wr_data;
      end
      if (resp && (count == '0)) o_err <= 1'b1;
      if (pop)   rptr <= inc(rptr);
      if (issue) wptr <= inc(wptr);
      if (issue && !pop)      count <= count + 1'b1;
      else if (!issue && pop) count <= count - 1'b1;
    end
  end

  // Tag storage needs no reset: validity comes from count and rptr.
  always_ff @(posedge i_clk) begin
    if (issue) tags[wptr] <= i_ld_rd;
  end

  always_comb begin
    logic [PW-1:0] idx;
    o_busy = '0;
    idx    = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = PW'((int'(rptr) + k) % DEPTH);
      if (k < int'(count)) o_busy[tags[idx]] = 1'b1;
    end
    o_busy[0] = 1'b0;
  end

endmodule

// File: tb/tb_reg_writeback.sv
// Bench for reg_writeback: directed scenarios then randomized traffic, all
// checked against a queue-based reference model of the write-side rules.
module tb_reg_writeback;
  localparam int DEPTH = 2;

  logic        i_clk = 1'b0;
  logic        i_rst, i_ce, i_alu_valid, i_ld_issue, i_ld_valid;
  logic [3:0]  i_alu_rd, i_ld_rd;
  logic [15:0] i_alu_data, i_ld_data;
  logic        o_alu_ready, o_ld_ready, o_we, o_err;
  logic [3:0]  o_w_addr;
  logic [15:0] o_w_data, o_busy;

  reg_writeback #(.DEPTH(DEPTH)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_ce(i_ce),
    .i_alu_valid(i_alu_valid), .i_alu_rd(i_alu_rd), .i_alu_data(i_alu_data),
    .o_alu_ready(o_alu_ready),
    .i_ld_issue(i_ld_issue), .i_ld_rd(i_ld_rd), .o_ld_ready(o_ld_ready),
    .i_ld_valid(i_ld_valid), .i_ld_data(i_ld_data),
    .o_we(o_we), .o_w_addr(o_w_addr), .o_w_data(o_w_data),
    .o_busy(o_busy), .o_err(o_err)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;

  // reference model state
  int          q[$];
  bit          m_we, m_err;
  logic [3:0]  m_addr;
  logic [15:0] m_data;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] m_busy();
    logic [15:0] b = '0;
    foreach (q[i]) if (q[i] != 0) b[q[i]] = 1'b1;
    return b;
  endfunction

  // One clock: check combinational handshakes, advance model at the edge,
  // then check registered outputs.
  task automatic cyc();
    #4;
    chk("ld_ready", o_ld_ready, i_ce && (q.size() < DEPTH));
    chk("alu_ready", o_alu_ready, i_ce && !i_ld_valid);
    @(posedge i_clk);
    if (i_rst) begin
      q.delete();
      m_we = 0; m_err = 0; m_addr = '0; m_data = '0;
    end else if (i_ce) begin
      bit iss;
      iss  = i_ld_issue && (q.size() < DEPTH);
      m_we = 0;
      if (i_ld_valid) begin
        if (q.size() == 0) m_err = 1;
        else begin
          int rd = q.pop_front();
          if (rd != 0) begin
            m_we = 1; m_addr = 4'(rd); m_data = i_ld_data;
          end
        end
      end else if (i_alu_valid && i_alu_rd != 0) begin
        m_we = 1; m_addr = i_alu_rd; m_data = i_alu_data;
      end
      if (iss) q.push_back(int'(i_ld_rd));
    end
    #1;
    chk("we", o_we, m_we);
    chk("w_addr", o_w_addr, m_addr);
    chk("w_data", o_w_data, m_data);
    chk("busy", o_busy, m_busy());
    chk("err", o_err, m_err);
  endtask

  task automatic go(input bit ce, input bit av, input logic [3:0] ard, input logic [15:0] ad,
                    input bit iss, input logic [3:0] ird, input bit lv, input logic [15:0] ld);
    i_ce = ce; i_alu_valid = av; i_alu_rd = ard; i_alu_data = ad;
    i_ld_issue = iss; i_ld_rd = ird; i_ld_valid = lv; i_ld_data = ld;
    cyc();
  endtask

  initial begin
    m_we = 0; m_err = 0; m_addr = '0; m_data = '0;
    i_rst = 1'b1;
    go(0, 0, 0, 0, 0, 0, 0, 0);
    go(0, 0, 0, 0, 0, 0, 0, 0);
    i_rst = 1'b0;
    go(0, 0, 0, 0, 0, 0, 0, 0);
    go(1, 0, 0, 0, 0, 0, 0, 0);
    // ALU write, then idle
    go(1, 1, 5, 16'h1234, 0, 0, 0, 0);
    chk("alu_w5", {o_we, o_w_addr, o_w_data}, {1'b1, 4'd5, 16'h1234});
    go(1, 0, 0, 0, 0, 0, 0, 0);
    // collision: load response beats the ALU
    go(1, 0, 0, 0, 1, 3, 0, 0);
    chk("busy3_set", o_busy[3], 1'b1);
    go(1, 0, 0, 0, 0, 0, 0, 0);
    go(1, 1, 7, 16'h0042, 0, 0, 1, 16'hBEEF);
    chk("coll_r3", {o_we, o_w_addr, o_w_data, o_busy[3]}, {1'b1, 4'd3, 16'hBEEF, 1'b0});
    go(1, 1, 7, 16'h0042, 0, 0, 0, 0);
    chk("coll_r7", {o_we, o_w_addr, o_w_data}, {1'b1, 4'd7, 16'h0042});
    // clock enable low holds outputs
    go(0, 1, 9, 16'h7777, 1, 2, 1, 16'h1111);
    chk("ce_hold", {o_we, o_w_addr, o_w_data}, {1'b1, 4'd7, 16'h0042});
    go(1, 0, 0, 0, 0, 0, 0, 0);
    // full queue with two loads to the same register
    go(1, 0, 0, 0, 1, 4, 0, 0);
    go(1, 0, 0, 0, 1, 4, 0, 0);
    go(1, 0, 0, 0, 1, 6, 0, 0);
    chk("full_busy", o_busy, 16'h0010);
    go(1, 0, 0, 0, 0, 0, 1, 16'h0001);
    chk("full_b4_keep", o_busy[4], 1'b1);
    go(1, 0, 0, 0, 0, 0, 1, 16'h0002);
    chk("full_b4_clr", {o_busy[4], o_w_data}, {1'b0, 16'h0002});
    // R0 load, then response coincident with a new issue
    go(1, 0, 0, 0, 1, 0, 0, 0);
    chk("r0_busy", o_busy, 16'h0000);
    go(1, 0, 0, 0, 1, 9, 1, 16'h5555);
    chk("r0_sim", {o_we, o_busy}, {1'b0, 16'h0200});
    go(1, 0, 0, 0, 0, 0, 1, 16'h0999);
    // response with empty queue
    go(1, 0, 0, 0, 0, 0, 1, 16'hDEAD);
    chk("err_set", {o_we, o_err}, {1'b0, 1'b1});
    go(1, 1, 2, 16'h0202, 0, 0, 0, 0);
    go(1, 0, 0, 0, 1, 8, 0, 0);
    chk("err_sticky", o_err, 1'b1);
    // reset mid-operation discards outstanding tags
    i_rst = 1'b1;
    go(1, 0, 0, 0, 0, 0, 0, 0);
    i_rst = 1'b0;
    go(1, 0, 0, 0, 0, 0, 1, 16'h0101);

    for (int n = 0; n < 3000; n++) begin
      i_rst = ($urandom_range(199) == 0);
      go($urandom_range(9) != 0,
         $urandom_range(1),
         4'($urandom_range(15)),
         16'($urandom),
         $urandom_range(2) != 0,
         4'($urandom_range(15)),
         (q.size() != 0) ? ($urandom_range(1) == 1) : ($urandom_range(19) == 0),
         16'($urandom));
    end
    i_rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/reg_writeback.md
# reg_writeback

Write-side controller for the CPU register file. It accepts single-cycle ALU results and multi-cycle memory load completions, arbitrates between them, and drives the register file write port (we / w_addr / w_data). It also tracks outstanding loads in an in-order queue and exports a per-register busy vector so issue logic can stall on read-after-load hazards.

## Interface
- `DEPTH`, default 2: maximum number of outstanding loads (load tag queue depth); must be ≥1.
- `i_clk` input, 1 bit: clock; all state updates on its rising edge.
- `i_rst` input, 1 bit: reset. Synchronous and active-high.
- `i_ce` input, 1 bit: clock enable. When it is 0, no state changes and no handshake completes.
- `i_alu_valid` input, 1 bit: an ALU result is offered.
- `i_alu_rd` input, 4 bits: destination register of the ALU result.
- `i_alu_data` input, 16 bits: ALU result.
- `o_alu_ready` output, 1 bit: the ALU result is accepted this cycle.
- `i_ld_issue` input, 1 bit: a load is being issued to memory.
- `i_ld_rd` input, 4 bits: destination register of the issued load.
- `o_ld_ready` output, 1 bit: a load may be issued (the queue has room).
- `i_ld_valid` input, 1 bit: load data is returning. Loads return in issue order.
- `i_ld_data` input, 16 bits: the returning load data.
- `o_we` output, 1 bit: register file write enable (registered).
- `o_w_addr` output, 4 bits: register file write address (registered).
- `o_w_data` output, 16 bits: register file write data (registered).
- `o_busy` output, 16 bits: bit r is set while any queued load targets r; bit 0 is always 0.
- `o_err` output, 1 bit: sticky flag; set when load data returns with the queue empty.

## Operation
- Load tag queue:
  - FIFO of `DEPTH` entries holding 4-bit rd values.
  - Read/write pointers wrap modulo `DEPTH`.
  - `count` ranges 0..`DEPTH`.
- `o_ld_ready` = `i_ce` & (`count` < `DEPTH`). It is combinational.
- An issue takes effect only when `i_ld_issue` & `o_ld_ready`.
- If `i_ld_issue` is asserted while ready is 0, the issue is ignored. Upstream must hold the issue.
- Load response:
  - Accepted whenever `i_ce` & `i_ld_valid`.
  - Pops the queue head and produces a write of `i_ld_data` to the head rd.
  - If `count` is 0, the response is dropped, no write occurs, and `o_err` is set.
- Arbitration: a load response has strict priority.
  - `o_alu_ready` = `i_ce` & ~`i_ld_valid`. It is combinational.
  - The ALU result is accepted only when `i_alu_valid` & `o_alu_ready`; otherwise the ALU must hold.
- Writes to R0:
  - Any accepted result with rd = 0 completes its handshake or pops the queue.
  - `o_we` stays 0 for that result.
  - Loads to R0 still occupy a queue slot but never set a busy bit.
- Simultaneous issue and response in one cycle:
  - Both happen; `count` is unchanged.
  - Both are legal even when `count` = `DEPTH`-1.
  - At `count` = `DEPTH`, the issue is blocked because ready is 0.
- `o_busy[r]` = OR over valid queue entries of (entry == r), for r ≠ 0.
  - Combinational from registered queue state, so it is exact with multiple loads to the same rd.
  - The bit clears the cycle after the last such load's response is accepted.
- `o_err`:
  - Cleared only by reset.
  - Does not block further operation.
- Reset (`i_rst`=1 at an edge, regardless of `i_ce`):
  - `count`, pointers, `o_we`, `o_w_addr`, `o_w_data`, and `o_err` are set to 0, so `o_busy` = 0.
  - Reset mid-operation discards all outstanding load tags; later responses set `o_err`.

## Timing
- Write latency is 1 cycle. An input accepted at edge N produces `o_we`/`o_w_addr`/`o_w_data` valid after edge N, for exactly one `i_ce` cycle.
- `o_we` is 0 after any enabled edge with no accepted write.
- While `i_ce` = 0, `o_we`, `o_w_addr` and `o_w_data` hold their values. The register file is itself `i_ce`-gated, so no duplicate write occurs.
- Throughput is one write per enabled cycle. An ALU result stalls for as many cycles as consecutive load responses.
- `o_busy` reflects an issue after the issuing edge. This is the same cycle the register file read data for a dependent instruction would be sampled, so issue logic must also compare against `i_ld_rd` combinationally.

## Test plan
- **Reset:** assert `i_rst` 2 cycles with `i_ce`=0 -> `o_we`=0, `o_w_addr`=0, `o_w_data`=0, `o_busy`=0, `o_err`=0, `o_ld_ready`=0 until `i_ce`=1, then 1.
- **ALU write:** ALU valid with rd=5, data=0x1234, no load -> `o_alu_ready`=1. Next cycle `o_we`=1, `o_w_addr`=5, `o_w_data`=0x1234. The following cycle `o_we`=0.
- **Collision:** issue load rd=3. Later, load data 0xBEEF arrives while ALU valid with rd=7, data=0x0042 -> `o_alu_ready`=0 for that cycle, and the write is R3=0xBEEF. The next cycle the ALU is accepted and R7=0x0042 is written one cycle after that. `o_busy[3]` is 1 until the response edge and 0 after it.
- **Full queue:** issue loads rd=4 and rd=4 (`DEPTH`=2) -> `o_ld_ready`=0 and `o_busy[4]`=1. After the first response (0x0001), `o_busy[4]` stays 1 and ready returns to 1. After the second response (0x0002), `o_busy[4]`=0, and the writes are R4=0x0001 then R4=0x0002.
- **R0 and simultaneous events:** load rd=0 issued -> `o_busy`=0. Its response arrives in the same cycle as a new issue with rd=9 -> no write (`o_we`=0), `count` stays 1, and `o_busy[9]`=1.
- **Error:** response with the queue empty -> `o_we`=0 and `o_err`=1, held through subsequent traffic until `i_rst`.
